// File: rtl/seg_disp_arbiter.sv
// Round-robin owner of the shared 6-digit seven-segment display.
// Each active source holds the display for HOLD_MAX+1 cycles; outputs lag grant by one cycle.
`timescale 1ns/1ps
module seg_disp_arbiter #(
  parameter logic [25:0] HOLD_MAX = 26'd49_999_999,
  parameter logic [19:0] DATA_MAX = 20'd999_999
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [2:0]  req,
  input  logic [19:0] data0,
  input  logic [19:0] data1,
  input  logic [19:0] data2,
  input  logic [5:0]  point0,
  input  logic [5:0]  point1,
  input  logic [5:0]  point2,
  input  logic        sign0,
  input  logic        sign1,
  input  logic        sign2,
  output logic [2:0]  grant,
  output logic [19:0] data,
  output logic [5:0]  point,
  output logic        sign,
  output logic        seg_en,
  output logic        ovf
);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t      state;
  logic [1:0]  last;
  logic [25:0] timer;
  logic [1:0]  nxt1, nxt2, win_idx;
  logic        win_found;
  logic [19:0] sel_data;
  logic [5:0]  sel_point;
  logic        sel_sign;

  // Search order last+1, last+2, last (mod 3); the owner's own bit is naturally last.
  always_comb begin
    nxt1      = (last == 2'd2) ? 2'd0 : last + 2'd1;
    nxt2      = (nxt1 == 2'd2) ? 2'd0 : nxt1 + 2'd1;
    win_found = 1'b1;
    win_idx   = last;
    if (req[nxt1])      win_idx = nxt1;
    else if (req[nxt2]) win_idx = nxt2;
    else if (req[last]) win_idx = last;
    else                win_found = 1'b0;
  end

  // Source mux keyed on the registered grant, so outputs follow grant by one cycle.
  always_comb begin
    sel_data  = '0;
    sel_point = '0;
    sel_sign  = 1'b0;
    case (grant)
      3'b001: begin sel_data = data0; sel_point = point0; sel_sign = sign0; end
      3'b010: begin sel_data = data1; sel_point = point1; sel_sign = sign1; end
      3'b100: begin sel_data = data2; sel_point = point2; sel_sign = sign2; end
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state  <= IDLE;
      last   <= 2'd2;
      timer  <= '0;
      grant  <= '0;
      data   <= '0;
      point  <= '0;
      sign   <= 1'b0;
      seg_en <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      seg_en <= |grant;
      point  <= sel_point;
      sign   <= sel_sign;
      if (sel_data > DATA_MAX) begin
        data <= DATA_MAX;
        ovf  <= 1'b1;
      end else begin
        data <= sel_data;
        ovf  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (win_found) begin
            grant <= 3'b001 << win_idx;
            last  <= win_idx;
            timer <= '0;
            state <= SHOW;
          end
        end
        SHOW: begin
          if (!req[last] || timer == HOLD_MAX) begin
            timer <= '0;
            if (win_found) begin
              grant <= 3'b001 << win_idx;
              last  <= win_idx;
            end else begin
              grant <= '0;
              state <= IDLE;
            end
          end else begin
            timer <= timer + 26'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed bench for seg_disp_arbiter with a short dwell (HOLD_MAX=9, i.e. 10 cycles).
`timescale 1ns/1ps
module tb_seg_disp_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [2:0]  req;
  logic [19:0] data0, data1, data2;
  logic [5:0]  point0, point1, point2;
  logic        sign0, sign1, sign2;
  logic [2:0]  grant;
  logic [19:0] data;
  logic [5:0]  point;
  logic        sign, seg_en, ovf;
  logic [31:0] obs;

  int n_cmp = 0;
  int n_err = 0;

  always #5 sys_clk = ~sys_clk;

  seg_disp_arbiter #(.HOLD_MAX(26'd9), .DATA_MAX(20'd999_999)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .point0(point0), .point1(point1), .point2(point2),
    .sign0(sign0), .sign1(sign1), .sign2(sign2),
    .grant(grant), .data(data), .point(point), .sign(sign),
    .seg_en(seg_en), .ovf(ovf)
  );

  assign obs = {grant, data, point, sign, seg_en, ovf};

  // {data, point, sign, seg_en, ovf} expected when the given owner is displayed (in-range data).
  function automatic logic [28:0] src_fields(input logic [2:0] g);
    case (g)
      3'b001:  return {data0, point0, sign0, 1'b1, 1'b0};
      3'b010:  return {data1, point1, sign1, 1'b1, 1'b0};
      3'b100:  return {data2, point2, sign2, 1'b1, 1'b0};
      default: return '0;
    endcase
  endfunction

  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] expv;
    req = 3'b111; sys_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (obs !== 32'd0) begin
        n_err++;
        $display("FAIL reset_hold cyc=%0d: got %h want %h", i, obs, 32'd0);
      end
    end
    req = 3'b000; sys_rst = 1'b0;
    expv = '0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL idle_after_reset cyc=%0d: got %h want %h", i, obs, expv);
      end
    end
  endtask

  task automatic test_single;
    logic [31:0] expv;
    data1 = 20'd87_654; sign1 = 1'b1; point1 = 6'b000010;
    req = 3'b010;
    tick;
    expv = {3'b010, 29'd0};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL single_grant: got %h want %h", obs, expv);
    end
    expv = {3'b010, 20'd87_654, 6'b000010, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 36; i++) begin
      tick;
      n_cmp++;
      if (obs !== expv) begin
        n_err++;
        $display("FAIL single_hold cyc=%0d: got %h want %h", i, obs, expv);
      end
    end
    req = 3'b000;
    tick;
    expv = {3'b000, 20'd87_654, 6'b000010, 1'b1, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL single_release_grant: got %h want %h", obs, expv);
    end
    tick;
    n_cmp++;
    if (obs !== 32'd0) begin
      n_err++;
      $display("FAIL single_release_blank: got %h want %h", obs, 32'd0);
    end
  endtask

  task automatic test_rotation;
    logic [2:0]  gseq [4];
    logic [2:0]  prev;
    logic [31:0] expv;
    gseq = '{3'b001, 3'b010, 3'b100, 3'b001};
    data0 = 20'd11; point0 = 6'h01; sign0 = 1'b0;
    data1 = 20'd22; point1 = 6'h02; sign1 = 1'b1;
    data2 = 20'd33; point2 = 6'h04; sign2 = 1'b0;
    req = 3'b111; sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    for (int s = 0; s < 4; s++) begin
      prev = (s == 0) ? 3'b000 : gseq[s-1];
      for (int c = 0; c < 10; c++) begin
        tick;
        expv = {gseq[s], (c == 0) ? src_fields(prev) : src_fields(gseq[s])};
        n_cmp++;
        if (obs !== expv) begin
          n_err++;
          $display("FAIL rotation s=%0d c=%0d: got %h want %h", s, c, obs, expv);
        end
      end
    end
  endtask

  task automatic test_drop_mid_dwell;
    logic [31:0] expv;
    req = 3'b011; sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      n_cmp++;
      if (grant !== 3'b001) begin
        n_err++;
        $display("FAIL drop_pre edge=%0d: got %b want %b", i, grant, 3'b001);
      end
    end
    req = 3'b010;
    tick;
    n_cmp++;
    if (grant !== 3'b010) begin
      n_err++;
      $display("FAIL drop_regrant: got %b want %b", grant, 3'b010);
    end
    req = 3'b011;
    for (int i = 7; i <= 15; i++) begin
      tick;
      n_cmp++;
      if (grant !== 3'b010) begin
        n_err++;
        $display("FAIL drop_full_dwell edge=%0d: got %b want %b", i, grant, 3'b010);
      end
    end
    tick;
    n_cmp++;
    if (grant !== 3'b001) begin
      n_err++;
      $display("FAIL drop_dwell_end: got %b want %b", grant, 3'b001);
    end
    req = 3'b000;
    tick;
    expv = {3'b000, src_fields(3'b001)};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL drop_all_grant: got %h want %h", obs, expv);
    end
    tick;
    n_cmp++;
    if (obs !== 32'd0) begin
      n_err++;
      $display("FAIL drop_all_blank: got %h want %h", obs, 32'd0);
    end
  endtask

  task automatic test_clamp;
    logic [31:0] expv;
    data0 = 20'd1_000_000; point0 = 6'b101010; sign0 = 1'b1;
    req = 3'b001; sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    tick;
    tick;
    expv = {3'b001, 20'd999_999, 6'b101010, 1'b1, 1'b1, 1'b1};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL clamp_over: got %h want %h", obs, expv);
    end
    data0 = 20'd999_999;
    tick;
    expv = {3'b001, 20'd999_999, 6'b101010, 1'b1, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL clamp_edge: got %h want %h", obs, expv);
    end
    data0 = 20'hF_FFFF;
    tick;
    expv = {3'b001, 20'd999_999, 6'b101010, 1'b1, 1'b1, 1'b1};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL clamp_max: got %h want %h", obs, expv);
    end
    data0 = 20'd123; point0 = 6'b000000; sign0 = 1'b0;
    tick;
    expv = {3'b001, 20'd123, 6'b000000, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL clamp_live: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_reset_mid_show;
    logic [31:0] expv;
    data0 = 20'd11; data1 = 20'd22; data2 = 20'd33;
    req = 3'b111; sys_rst = 1'b1;
    tick;
    sys_rst = 1'b0;
    for (int i = 0; i < 21; i++) tick;
    n_cmp++;
    if (grant !== 3'b100) begin
      n_err++;
      $display("FAIL midshow_owner: got %b want %b", grant, 3'b100);
    end
    tick;
    tick;
    expv = {3'b100, src_fields(3'b100)};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL midshow_data: got %h want %h", obs, expv);
    end
    sys_rst = 1'b1;
    tick;
    n_cmp++;
    if (obs !== 32'd0) begin
      n_err++;
      $display("FAIL midshow_reset: got %h want %h", obs, 32'd0);
    end
    sys_rst = 1'b0;
    tick;
    expv = {3'b001, 29'd0};
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL midshow_restart: got %h want %h", obs, expv);
    end
  endtask

  initial begin
    sys_rst = 1'b1; req = '0;
    data0 = '0; data1 = '0; data2 = '0;
    point0 = '0; point1 = '0; point2 = '0;
    sign0 = 1'b0; sign1 = 1'b0; sign2 = 1'b0;
    test_reset;
    test_single;
    test_rotation;
    test_drop_mid_dwell;
    test_clamp;
    test_reset_mid_show;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_disp_arbiter.md
# seg_disp_arbiter

Round-robin scheduler that shares the single 6-digit dynamic seven-segment display between three requesting sources. It sits directly upstream of `seg_dynamic` and drives its `data`/`point`/`sign`/`seg_en` inputs. Each active requester holds the display for a programmable dwell time; then the display rotates to the next active requester. The block also blanks the display when nobody requests it and clamps out-of-range values.

## Interface
- `HOLD_MAX`, default `26'd49_999_999`: dwell counter terminal value; dwell = HOLD_MAX+1 cycles (1 s at 50 MHz).
- `DATA_MAX`, default `20'd999_999`: largest displayable magnitude.
- `sys_clk`  in  1  system clock, all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `req`  in  3  per-source display request, bit i = source i.
- `data0`, `data1`, `data2`  in  20 each  unsigned magnitude of source i.
- `point0`, `point1`, `point2`  in  6 each  decimal-point mask of source i.
- `sign0`, `sign1`, `sign2`  in  1 each  negative sign of source i.
- `grant`  out  3  one-hot current owner; 0 when idle.
- `data`  out  20  magnitude to display driver.
- `point`  out  6  decimal-point mask to display driver.
- `sign`  out  1  sign to display driver.
- `seg_en`  out  1  display enable to display driver.
- `ovf`  out  1  selected source's data exceeds DATA_MAX.

## Operation
- States: IDLE (grant=0) and SHOW (grant one-hot).
- Internal registers:
  - `last` (2 bits) holds the index of the last granted source; reset value 2.
  - `timer` (26 bits) holds the dwell count; reset value 0.
- Arbitration search order: `last`+1, `last`+2, `last` (mod 3). The first index with `req` set wins.
- IDLE:
  - If `req`==0, stay in IDLE.
  - Otherwise, at this edge: grant the search winner, `last`<=winner, `timer`<=0, go to SHOW.
- SHOW, granted source still requesting and `timer`<HOLD_MAX: `timer`++ and grant is held.
- SHOW, `timer`==HOLD_MAX: re-arbitrate and set `timer`<=0.
  - Another source is active: the winner is the next one in circular order.
  - Only the current source is active: the grant is kept and a new dwell starts.
  - `req`==0: go to IDLE.
- SHOW, granted source drops `req`:
  - At the next edge, re-arbitrate immediately (same search) and set `timer`<=0.
  - If no source is active, go to IDLE.
- The owner follows live inputs: `data`/`point`/`sign` are re-registered every cycle from the granted source. There is no snapshot.
- Clamp:
  - If the selected data > DATA_MAX: `data`<=DATA_MAX and `ovf`<=1.
  - Otherwise: `data`<=selected data and `ovf`<=0.
- `point` and `sign` pass through unmodified.
- While idle, `data`/`point`/`sign`/`ovf` <= 0 and `seg_en` <= 0.
- Reset (any state): all outputs 0, `last`=2, `timer`=0, state IDLE. Reset overrides all other activity on that edge.

## Timing
- Reset values: `grant`=000, `data`=0, `point`=0, `sign`=0, `seg_en`=0, `ovf`=0.
- `req` is sampled at edge k; `grant` updates at edge k.
- `data`/`point`/`sign`/`ovf`/`seg_en` reflect the new grant at edge k+1, i.e. one cycle after `grant`.
- `seg_en` is never high with stale source data. It is the registered form of (`grant`!=0).
- Dwell: while other requesters wait, `grant` holds a given owner for exactly HOLD_MAX+1 cycles.
- Simultaneous events:
  - Owner drops `req` on the same edge `timer` reaches HOLD_MAX: handled as a single re-arbitration with the owner excluded.
  - New `req` bits asserted mid-dwell do not shorten the current dwell.
- Source input changes during SHOW appear on the outputs one cycle later.

## Test plan
- Reset: hold `sys_rst`=1 for 3 cycles with `req`=111. Required: all outputs 0 throughout. After release with `req`=000, `seg_en` stays 0 and `grant`=000.
- Single source (HOLD_MAX=9): `req`=010, `data1`=87_654, `sign1`=1, `point1`=000010. Required: `grant`=010 at the first edge; one edge later `data`=87_654, `sign`=1, `point`=000010, `seg_en`=1. `grant` stays 010 for >30 cycles.
- Rotation (HOLD_MAX=9): `req`=111 from reset. Required: `grant` sequence 001, 010, 100, 001, each held exactly 10 cycles.
- Drop mid-dwell: `req`=011 with `grant`=001. Drop `req[0]` when `timer`=4. Required: `grant`=010 at the next edge, then held a full 10 cycles. Drop `req[1]` as well: `grant`=000, and one cycle later `seg_en`=0.
- Clamp: `data0`=20'd1_000_000 granted. Required: `data`=999_999, `ovf`=1. Change `data0` to 999_999: required `data`=999_999, `ovf`=0 one cycle later.
- Reset mid-SHOW: assert `sys_rst` while `grant`=100. Required: all outputs 0 at the next edge. After release with `req`=111, the first `grant` is 001.
